// File: rtl/mna_axi_resp_driver.sv
// MNA response-path stage: pairs NoC response header/body flits and drives the
// AXI4-Lite R or B channel, flagging protocol faults and body timeouts.
module mna_axi_resp_driver #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FLIT_WIDTH   = 37,
  parameter int unsigned BODY_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] flit_data,
  input  logic                  flit_valid,
  output logic                  flit_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  proto_err
);

  localparam int unsigned CNT_W = (BODY_TIMEOUT > 0) ? $clog2(BODY_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (BODY_TIMEOUT > 0) ? CNT_W'(BODY_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    FT_IDLE = 2'b00,
    FT_BODY = 2'b01,
    FT_HDR  = 2'b10,
    FT_RSV  = 2'b11
  } ftype_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BODY,
    S_R_OUT,
    S_B_OUT
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  bvalid_q, bvalid_d;
  logic                  perr_q, perr_d;

  ftype_e ftype;
  logic   accept;
  logic   timeout_hit;
  logic   unused_flit_bits;

  assign ftype            = ftype_e'(flit_data[FLIT_WIDTH-1:FLIT_WIDTH-2]);
  assign unused_flit_bits = ^flit_data[FLIT_WIDTH-3:DATA_WIDTH];

  // Ready depends on state only; held low while reset is asserted.
  assign flit_ready  = !rst && ((state_q == S_IDLE) || (state_q == S_WAIT_BODY));
  assign accept      = flit_valid && flit_ready;
  assign timeout_hit = (BODY_TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rvalid_d = rvalid_q;
    bresp_d  = bresp_q;
    bvalid_d = bvalid_q;
    perr_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (ftype)
            FT_HDR: begin
              if (flit_data[0]) begin
                rresp_d = flit_data[2:1];
                cnt_d   = '0;
                state_d = S_WAIT_BODY;
              end else begin
                bresp_d  = flit_data[2:1];
                bvalid_d = 1'b1;
                state_d  = S_B_OUT;
              end
            end
            FT_BODY, FT_RSV: perr_d = 1'b1;
            default: ;
          endcase
        end
      end

      S_WAIT_BODY: begin
        // A body arriving in the timeout cycle takes priority over the timeout.
        if (accept && (ftype == FT_BODY)) begin
          rdata_d  = flit_data[DATA_WIDTH-1:0];
          rvalid_d = 1'b1;
          state_d  = S_R_OUT;
        end else begin
          if (accept && ((ftype == FT_HDR) || (ftype == FT_RSV))) perr_d = 1'b1;
          if (timeout_hit) begin
            rdata_d  = '0;
            rresp_d  = 2'b10;
            rvalid_d = 1'b1;
            perr_d   = 1'b1;
            state_d  = S_R_OUT;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_R_OUT: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      S_B_OUT: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rvalid_q <= 1'b0;
      bresp_q  <= '0;
      bvalid_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rvalid_q <= rvalid_d;
      bresp_q  <= bresp_d;
      bvalid_q <= bvalid_d;
      perr_q   <= perr_d;
    end
  end

  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign rvalid    = rvalid_q;
  assign bresp     = bresp_q;
  assign bvalid    = bvalid_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_mna_axi_resp_driver.sv
// Scoreboard bench for mna_axi_resp_driver: transaction-level reference model
// pushes expected responses; a monitor pops them at each R/B handshake.
module tb_mna_axi_resp_driver;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [36:0] flit_data;
  logic        flit_valid;
  logic        flit_ready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        proto_err;

  mna_axi_resp_driver #(
    .DATA_WIDTH  (32),
    .FLIT_WIDTH  (37),
    .BODY_TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flit_data (flit_data),
    .flit_valid(flit_valid),
    .flit_ready(flit_ready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    logic [1:0]  resp;
  } resp_t;

  resp_t       exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  int unsigned rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: begin rready = 1'b1; bready = 1'b1; end
      1: begin rready = 1'($urandom_range(0, 1)); bready = 1'($urandom_range(0, 1)); end
      default: begin rready = 1'b0; bready = 1'b0; end
    endcase
  end

  // Reference model: evaluated just before each rising edge using the inputs
  // that edge will see; checks what the previous edge should have produced.
  bit          m_wait, m_busy, m_err_nx;
  int unsigned m_age;
  logic [1:0]  m_rresp;
  resp_t       m_cur;

  always @(negedge clk) begin
    bit         acc, err;
    logic [1:0] ty;
    resp_t      r;
    if (rst) begin
      m_wait = 0; m_busy = 0; m_err_nx = 0; m_age = 0; m_rresp = 2'b00;
      exp_q.delete();
    end else begin
      chk("proto_err", proto_err, m_err_nx);
      chk("flit_ready", flit_ready, !m_busy);
      chk("rvalid", rvalid, m_busy && m_cur.is_read);
      chk("bvalid", bvalid, m_busy && !m_cur.is_read);
      if (m_busy && m_cur.is_read) begin
        chk("rdata_hold", rdata, m_cur.data);
        chk("rresp_hold", rresp, m_cur.resp);
      end
      if (m_busy && !m_cur.is_read) chk("bresp_hold", bresp, m_cur.resp);

      err = 0;
      acc = flit_valid && !m_busy;
      ty  = flit_data[36:35];
      if (m_busy) begin
        if (m_cur.is_read ? rready : bready) m_busy = 0;
      end else if (m_wait) begin
        if (acc && ty == 2'b01) begin
          r = '{1'b1, flit_data[31:0], m_rresp};
          exp_q.push_back(r); m_cur = r; m_busy = 1; m_wait = 0;
        end else begin
          if (acc && (ty == 2'b10 || ty == 2'b11)) err = 1;
          if (m_age == TO - 1) begin
            r = '{1'b1, 32'h0, 2'b10};
            exp_q.push_back(r); m_cur = r; m_busy = 1; m_wait = 0; err = 1;
          end else begin
            m_age++;
          end
        end
      end else if (acc) begin
        if (ty == 2'b10) begin
          if (flit_data[0]) begin
            m_wait = 1; m_age = 0; m_rresp = flit_data[2:1];
          end else begin
            r = '{1'b0, 32'h0, flit_data[2:1]};
            exp_q.push_back(r); m_cur = r; m_busy = 1;
          end
        end else if (ty != 2'b00) begin
          err = 1;
        end
      end
      m_err_nx = err;
    end
  end

  // Monitor: pops one expected response per completed handshake.
  always @(negedge clk) begin
    resp_t e;
    if (!rst) begin
      if (rvalid && bvalid) chk("both_valid", 1, 0);
      if ((rvalid && rready) || (bvalid && bready)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_kind", rvalid, e.is_read);
          if (rvalid) begin
            chk("rdata", rdata, e.data);
            chk("rresp", rresp, e.resp);
          end else begin
            chk("bresp", bresp, e.resp);
          end
        end
      end
    end
  end

  task automatic idle(input int unsigned n);
    flit_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_flit(input logic [36:0] f);
    int unsigned n    = 0;
    bit          done = 0;
    flit_data  = f;
    flit_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (flit_ready) done = 1;
      @(posedge clk); #1;
      if (!done) begin
        n++;
        if (n > 200) begin
          chk("flit_accept_timeout", 0, 1);
          done = 1;
        end
      end
    end
    flit_valid = 1'b0;
  endtask

  initial begin
    logic [36:0] f;
    int unsigned r;
    rst = 1'b1; flit_valid = 1'b0; flit_data = '0; rready = 1'b1; bready = 1'b1;
    #3;
    chk("rst_flit_ready", flit_ready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_proto_err", proto_err, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Write response, one cycle latency, back in IDLE two cycles after accept.
    send_flit(37'h10_0000_0002);
    chk("t1_bvalid", bvalid, 1);
    chk("t1_bresp", bresp, 2'b01);
    idle(1);
    chk("t1_bvalid_done", bvalid, 0);
    chk("t1_ready_back", flit_ready, 1);
    idle(2);

    // Read response held off by rready.
    rdy_mode = 2;
    send_flit(37'h10_0000_0001);
    send_flit(37'h08_DEAD_BEEF);
    idle(3);
    chk("t2_rvalid", rvalid, 1);
    chk("t2_rdata", rdata, 32'hDEADBEEF);
    chk("t2_ready_low", flit_ready, 0);
    rdy_mode = 0;
    idle(3);

    // Orphan body and reserved type.
    send_flit(37'h08_0000_1234);
    send_flit(37'h18_0000_0000);
    idle(3);

    // Timeout, then body landing exactly in the timeout cycle.
    send_flit(37'h10_0000_0001);
    idle(TO + 4);
    send_flit(37'h10_0000_0001);
    idle(TO - 1);
    send_flit(37'h08_0000_5A5A);
    idle(3);

    // Header while a body is pending.
    send_flit(37'h10_0000_0001);
    send_flit(37'h10_0000_0002);
    send_flit(37'h08_0000_00AA);
    idle(3);

    // Reset while a read response is presented.
    rdy_mode = 2;
    send_flit(37'h10_0000_0001);
    send_flit(37'h08_0BAD_F00D);
    idle(2);
    #2 rst = 1'b1;
    #1;
    chk("t6_rvalid_async", rvalid, 0);
    chk("t6_ready_in_rst", flit_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    chk("t6_ready_after", flit_ready, 1);
    chk("t6_rvalid_after", rvalid, 0);
    idle(4);

    // Randomized traffic.
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      idle($urandom_range(0, 3));
      r = $urandom_range(0, 99);
      f[34:0]  = {3'($urandom), $urandom};
      f[36:35] = (r < 40) ? 2'b10 : (r < 75) ? 2'b01 : (r < 85) ? 2'b00 : 2'b11;
      send_flit(f);
    end

    rdy_mode = 0;
    idle(TO + 10);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
